// File: rtl/pump_actuation_seq_pkg.sv
// Shared types and constants for the pump actuation sequencer.
// Pattern bit order is {air_valve1, air_dc, air_valve2}.
package pump_actuation_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VOPEN    = 3'd1,
    ST_FILL     = 3'd2,
    ST_SEAL_IN  = 3'd3,
    ST_PUSH     = 3'd4,
    ST_SEAL_OUT = 3'd5,
    ST_VCLOSE   = 3'd6
  } state_e;

  localparam logic [2:0] PAT_IDLE     = 3'b101;
  localparam logic [2:0] PAT_FILL     = 3'b001;
  localparam logic [2:0] PAT_SEAL_IN  = 3'b101;
  localparam logic [2:0] PAT_PUSH     = 3'b110;
  localparam logic [2:0] PAT_SEAL_OUT = 3'b111;

  // Reverse pumping mirrors the inlet and outlet valves.
  function automatic logic [2:0] swap_v1v2(input logic [2:0] pat);
    return {pat[0], pat[1], pat[2]};
  endfunction

  // Forward-direction pump pattern held in a given state.
  function automatic logic [2:0] state_pattern(input state_e st);
    logic [2:0] pat;
    case (st)
      ST_FILL:     pat = PAT_FILL;
      ST_SEAL_IN:  pat = PAT_SEAL_IN;
      ST_PUSH:     pat = PAT_PUSH;
      ST_SEAL_OUT: pat = PAT_SEAL_OUT;
      default:     pat = PAT_IDLE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/pump_actuation_seq_timer.sv
// Phase timer: loadable down-counter; expire_o is high while the count is zero.
module pump_phase_timer
  import pump_actuation_seq_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q;

  // Reload on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {TIMER_W{1'b0}};
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != {TIMER_W{1'b0}}) begin
      count_q <= count_q - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign expire_o = (count_q == {TIMER_W{1'b0}});

endmodule

// File: rtl/pump_actuation_seq.sv
// Pneumatic sequencer for a 3-chamber peristaltic pump plus downstream
// isolation valve. Optional macro PUMP_ACTUATION_SEQ_REVERSE_EN enables the
// reverse pumping direction; without it req_reverse is ignored.
module pump_actuation_seq
  import pump_actuation_seq_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int STROKE_W     = 8,
  parameter int TIMER_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [STROKE_W-1:0] req_strokes,
  input  logic                req_reverse,
  input  logic                abort,
  output logic                air_valve1,
  output logic                air_dc,
  output logic                air_valve2,
  output logic                air_valve_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STROKE_W-1:0] strokes_done
);

  localparam logic [TIMER_W-1:0]  PHASE_LOAD = TIMER_W'(PHASE_CYCLES - 1);
  localparam logic [STROKE_W-1:0] STROKE_ONE = STROKE_W'(1);

  state_e              state_q, state_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d;
  logic [STROKE_W-1:0] sdone_q, sdone_d;
  logic                aborted_q, aborted_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                vout_q, vout_d;
  logic [2:0]          pat_q, pat_d;
  logic [2:0]          pat_fwd_s;
  logic                accept_s;
  logic                timer_load_s;
  logic                timer_expire_s;

`ifdef PUMP_ACTUATION_SEQ_REVERSE_EN
  logic                rev_q, rev_d;
`else
  logic                unused_rev_s;
  assign unused_rev_s = req_reverse;
`endif

  assign req_ready = (state_q == ST_IDLE) && rst_n;
  assign accept_s  = req_valid && req_ready;

  pump_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load_s),
    .load_val_i (PHASE_LOAD),
    .expire_o   (timer_expire_s)
  );

  // Next-state logic: request acceptance, phase stepping, stroke counting, abort.
  always_comb begin
    state_d   = state_q;
    strokes_d = strokes_q;
    sdone_d   = sdone_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
`ifdef PUMP_ACTUATION_SEQ_REVERSE_EN
    rev_d     = rev_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          strokes_d = req_strokes;
          sdone_d   = {STROKE_W{1'b0}};
          aborted_d = 1'b0;
`ifdef PUMP_ACTUATION_SEQ_REVERSE_EN
          rev_d     = req_reverse;
`endif
          if (req_strokes == {STROKE_W{1'b0}}) begin
            done_d  = 1'b1;
          end else begin
            state_d = ST_VOPEN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VOPEN, ST_FILL, ST_SEAL_IN, ST_PUSH: begin
        if (abort) begin
          state_d   = ST_VCLOSE;
          aborted_d = 1'b1;
        end else if (timer_expire_s) begin
          case (state_q)
            ST_VOPEN:   state_d = ST_FILL;
            ST_FILL:    state_d = ST_SEAL_IN;
            ST_SEAL_IN: state_d = ST_PUSH;
            default:    state_d = ST_SEAL_OUT;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_SEAL_OUT: begin
        if (abort) begin
          state_d   = ST_VCLOSE;
          aborted_d = 1'b1;
        end else if (timer_expire_s) begin
          sdone_d = sdone_q + STROKE_ONE;
          if (sdone_q == (strokes_q - STROKE_ONE)) begin
            state_d = ST_VCLOSE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_VCLOSE: begin
        if (timer_expire_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a register.
  always_comb begin
    pat_fwd_s    = state_pattern(state_d);
`ifdef PUMP_ACTUATION_SEQ_REVERSE_EN
    if (rev_d) begin
      pat_d = swap_v1v2(pat_fwd_s);
    end else begin
      pat_d = pat_fwd_s;
    end
`else
    pat_d        = pat_fwd_s;
`endif
    case (state_d)
      ST_VOPEN, ST_FILL, ST_SEAL_IN, ST_PUSH, ST_SEAL_OUT: vout_d = 1'b0;
      default:                                             vout_d = 1'b1;
    endcase
    busy_d       = (state_d != ST_IDLE);
    timer_load_s = (state_d != state_q);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      strokes_q <= {STROKE_W{1'b0}};
      sdone_q   <= {STROKE_W{1'b0}};
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      vout_q    <= 1'b1;
      pat_q     <= PAT_IDLE;
    end else begin
      state_q   <= state_d;
      strokes_q <= strokes_d;
      sdone_q   <= sdone_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      vout_q    <= vout_d;
      pat_q     <= pat_d;
    end
  end

`ifdef PUMP_ACTUATION_SEQ_REVERSE_EN
  // Latched pump direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rev_q <= 1'b0;
    end else begin
      rev_q <= rev_d;
    end
  end
`endif

  assign air_valve1    = pat_q[2];
  assign air_dc        = pat_q[1];
  assign air_valve2    = pat_q[0];
  assign air_valve_out = vout_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign strokes_done  = sdone_q;

endmodule
